// File: rtl/vga_scanout.sv
// VGA scanout engine: parametrised video timing generator with a pixel FIFO feeding registered DAC pins.
// Optional SOF resynchronisation (per-entry sof bit, RUN/HUNT/WAIT_ORIGIN FSM, desync flag): VGA_SCANOUT_SOF_RESYNC_EN.
module vga_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [3*COLOR_W-1:0]   in_data,
  input  logic                   in_valid,
  input  logic                   in_sof,
  output logic                   in_ready,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   vga_blank_n,
  output logic                   vga_sync_n,
  output logic                   frame_start,
  output logic                   underflow,
`ifdef VGA_SCANOUT_SOF_RESYNC_EN
  output logic                   desync,
  output logic [1:0]             dbg_state,
`endif
  input  logic                   clear_status
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = 3 * COLOR_W;
`ifdef VGA_SCANOUT_SOF_RESYNC_EN
  localparam int EW = PW + 1;
`else
  localparam int EW = PW;
`endif

  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(FIFO_DEPTH);
  localparam logic          HS_ON     = (HS_POL != 0);
  localparam logic          VS_ON     = (VS_POL != 0);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          slot_active, slot_origin, hs_on, vs_on;

  // Counters sit at the origin while disabled so a rising enable starts a fresh frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign slot_active = enable && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign slot_origin = (h_cnt == '0) && (v_cnt == '0);
  assign hs_on       = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_on       = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  // Handshake: a pixel transfers on a clock edge where in_valid && in_ready; in_ready is !full and never looks at in_valid.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full, fifo_empty, push, pop, show, uf_set;
  logic [EW-1:0] head, entry_in;

  assign fifo_full  = (count == DEPTH_L);
  assign fifo_empty = (count == '0);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign head       = mem[rd_ptr];

`ifdef VGA_SCANOUT_SOF_RESYNC_EN
  assign entry_in = {in_sof, in_data};
`else
  logic unused_sof;
  assign unused_sof = in_sof;
  assign entry_in   = in_data;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef VGA_SCANOUT_SOF_RESYNC_EN
  typedef enum logic [1:0] {RUN = 2'd0, HUNT = 2'd1, WAIT_ORIGIN = 2'd2} scan_state_t;
  scan_state_t state, state_nx;
  logic        ds_set, head_sof;

  assign head_sof  = head[PW];
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    show     = 1'b0;
    uf_set   = 1'b0;
    ds_set   = 1'b0;
    if (enable) begin
      case (state)
        RUN: begin
          if (slot_active) begin
            if (fifo_empty) begin
              uf_set = 1'b1;
            end else if (slot_origin && !head_sof) begin
              ds_set   = 1'b1;
              state_nx = HUNT;
            end else if (!slot_origin && head_sof) begin
              ds_set   = 1'b1;
              state_nx = WAIT_ORIGIN;
            end else begin
              pop  = 1'b1;
              show = 1'b1;
            end
          end
        end
        HUNT: begin
          // Discard stale pixels until the next frame's first pixel reaches the head.
          if (!fifo_empty) begin
            if (head_sof) state_nx = WAIT_ORIGIN;
            else          pop      = 1'b1;
          end
        end
        WAIT_ORIGIN: begin
          if (slot_origin && !fifo_empty) begin
            pop      = 1'b1;
            show     = 1'b1;
            state_nx = RUN;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          desync <= 1'b0;
    else if (ds_set)       desync <= 1'b1;
    else if (clear_status) desync <= 1'b0;
  end
`else
  always_comb begin
    pop    = slot_active && !fifo_empty;
    show   = pop;
    uf_set = slot_active && fifo_empty;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          underflow <= 1'b0;
    else if (uf_set)       underflow <= 1'b1;
    else if (clear_status) underflow <= 1'b0;
  end

  // Every pin is a register reflecting the slot decoded on the previous cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {vga_r, vga_g, vga_b} <= '0;
      vga_hs      <= !HS_ON;
      vga_vs      <= !VS_ON;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      {vga_r, vga_g, vga_b} <= '0;
      vga_hs      <= !HS_ON;
      vga_vs      <= !VS_ON;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= show ? head[PW-1:0] : '0;
      vga_hs      <= hs_on ? HS_ON : !HS_ON;
      vga_vs      <= vs_on ? VS_ON : !VS_ON;
      vga_blank_n <= slot_active;
      frame_start <= slot_origin;
    end
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_scanout.sv
// Testbench for vga_scanout with a 14x7 timing: reference slot/FIFO model with an expected-pixel queue plus directed checks.
`timescale 1ns/1ps
module tb_vga_scanout;

  logic        clk = 1'b0;
  logic        reset_n, enable, in_valid, in_sof, clear_status;
  logic [23:0] in_data;
  logic        in_ready;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start, underflow;
`ifdef VGA_SCANOUT_SOF_RESYNC_EN
  logic        desync;
  logic [1:0]  dbg_state;
`endif

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .COLOR_W(8), .FIFO_DEPTH(16), .HS_POL(0), .VS_POL(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
    .frame_start(frame_start), .underflow(underflow),
`ifdef VGA_SCANOUT_SOF_RESYNC_EN
    .desync(desync), .dbg_state(dbg_state),
`endif
    .clear_status(clear_status)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_sof = 1'b0; clear_status = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic push_px(input logic [23:0] d, input logic s);
    int guard = 0;
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("push_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_sof = s;
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [24:0] exp_q[$];
  int bh = 0, bv = 0;
  int m_st = 0;
  logic m_uf = 1'b0, m_ds = 1'b0;
  int fs_cnt = 0, bn_cnt = 0;

  always @(posedge clk) begin
    logic [23:0] e_rgb;
    logic [4:0]  e_sig;
    logic        act, org, ne, uf_set, ds_set, en;
    logic [24:0] hd;
    e_rgb = '0; e_sig = 5'b11000; uf_set = 1'b0; ds_set = 1'b0;
    en = enable;
    if (!reset_n) begin
      exp_q.delete();
      m_uf = 1'b0; m_ds = 1'b0; m_st = 0; bh = 0; bv = 0;
    end else begin
      if (en) begin
        act = (bh < 8) && (bv < 4);
        org = (bh == 0) && (bv == 0);
        e_sig = {!(bh >= 10 && bh < 12), !(bv == 5), act, org, 1'b0};
        ne = (exp_q.size() > 0);
        hd = ne ? exp_q[0] : '0;
`ifdef VGA_SCANOUT_SOF_RESYNC_EN
        case (m_st)
          0: if (act) begin
               if (!ne) uf_set = 1'b1;
               else if (org && !hd[24]) begin ds_set = 1'b1; m_st = 1; end
               else if (!org && hd[24]) begin ds_set = 1'b1; m_st = 2; end
               else begin e_rgb = hd[23:0]; void'(exp_q.pop_front()); end
             end
          1: if (ne) begin
               if (hd[24]) m_st = 2;
               else void'(exp_q.pop_front());
             end
          default: if (org && ne) begin
               e_rgb = hd[23:0]; void'(exp_q.pop_front()); m_st = 0;
             end
        endcase
`else
        if (act) begin
          if (ne) begin e_rgb = hd[23:0]; void'(exp_q.pop_front()); end
          else uf_set = 1'b1;
        end
`endif
        if (bh == 13) begin bh = 0; bv = (bv == 6) ? 0 : bv + 1; end
        else bh = bh + 1;
      end else begin
        bh = 0; bv = 0;
      end
      if (uf_set) m_uf = 1'b1; else if (clear_status) m_uf = 1'b0;
      if (ds_set) m_ds = 1'b1; else if (clear_status) m_ds = 1'b0;
      if (in_valid && in_ready) exp_q.push_back({in_sof, in_data});
    end
    #1;
    check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
    check("hs_vs_blank_fs_syncn", 32'({vga_hs, vga_vs, vga_blank_n, frame_start, vga_sync_n}), 32'(e_sig));
    check("underflow", 32'(underflow), 32'(m_uf));
    check("in_ready", 32'(in_ready), 32'(exp_q.size() < 16));
`ifdef VGA_SCANOUT_SOF_RESYNC_EN
    check("desync", 32'(desync), 32'(m_ds));
`endif
    if (frame_start) fs_cnt++;
    if (vga_blank_n) bn_cnt++;
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    in_data = '0; clear_status = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_pins", 32'({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start, underflow, vga_sync_n}),
          32'({24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    reset_n = 1'b1;

    // 1: free-running timing with an empty FIFO
    @(negedge clk);
    enable = 1'b1; fs_cnt = 0;
    repeat (11) @(negedge clk);
    check("hs_low_h10", 32'(vga_hs), 32'd0);
    repeat (2) @(negedge clk);
    check("hs_high_h12", 32'(vga_hs), 32'd1);
    repeat (183) @(negedge clk);
    check("fs_two_frames", 32'(fs_cnt), 32'd2);
    check("uf_empty_run", 32'(underflow), 32'd1);

    // 2: full 32-pixel frame, prefilled before enable
    do_reset();
    for (int i = 1; i <= 16; i++) push_px(24'(i), i == 1);
    enable = 1'b1; bn_cnt = 0;
    fork
      for (int i = 17; i <= 32; i++) push_px(24'(i), 1'b0);
      repeat (98) @(negedge clk);
    join
    check("blank_n_count", 32'(bn_cnt), 32'd32);
    check("uf_full_frame", 32'(underflow), 32'd0);
    check("sb_drained_f", 32'(exp_q.size()), 32'd0);

    // 3: backpressure while disabled
    do_reset();
    for (int i = 0; i < 16; i++) push_px(24'h200 + 24'(i), i == 0);
    check("ready_full", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 24'h200010; in_sof = 1'b0;
    repeat (5) @(negedge clk);
    check("ready_held", 32'(in_ready), 32'd0);
    enable = 1'b1;
    for (int g = 0; g < 50 && !in_ready; g++) @(negedge clk);
    check("ready_resume", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("sb_drained_bp", 32'(exp_q.size()), 32'd0);

    // 4: starvation mid-line and status clear
    do_reset();
    for (int i = 0; i < 5; i++) push_px(24'h100 + 24'(i), i == 0);
    enable = 1'b1;
    repeat (8) @(negedge clk);
    check("starve_black", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("starve_uf", 32'(underflow), 32'd1);
    @(negedge clk);
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    check("uf_cleared", 32'(underflow), 32'd0);

    // 5: asynchronous reset during line 2
    do_reset();
    for (int i = 0; i < 10; i++) push_px(24'h300 + 24'(i), i == 0);
    enable = 1'b1;
    repeat (30) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pins", 32'({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start, underflow}),
          32'({24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    enable = 1'b0; reset_n = 1'b1;
    push_px(24'hABCDEF, 1'b1);
    enable = 1'b1;
    for (int g = 0; g < 20 && !vga_blank_n; g++) @(negedge clk);
    check("first_after_rst", 32'({vga_r, vga_g, vga_b}), 32'hABCDEF);

`ifdef VGA_SCANOUT_SOF_RESYNC_EN
    // 6: stale pixels ahead of a frame start
    do_reset();
    for (int i = 1; i <= 3; i++) push_px(24'h111111 * 24'(i), 1'b0);
    for (int i = 1; i <= 12; i++) push_px(24'hA00000 + 24'(i), i == 1);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("desync_set", 32'(desync), 32'd1);
    repeat (96) @(negedge clk);
    check("sof_at_origin", 32'({vga_r, vga_g, vga_b}), 32'hA00001);
    repeat (30) @(negedge clk);
    check("sb_drained_rs", 32'(exp_q.size()), 32'd0);
`endif

    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
